m_dram_arbiter: RTL and testbench

- Shares the single DRAM controller port between three requesters: the MMU page-table walker (PTE read and PTE A/D write-back), the CPU data port and the CPU instruction-fetch port.
- Sequences one transaction at a time.
- Returns read data and a completion pulse to the owning requester.
- Sits between m_mmu/CPU and the DRAM controller, and replaces ad-hoc muxing of the DRAM address, write-enable and data signals.

---
 rtl/m_dram_arbiter_pkg.sv | 17 +
 rtl/m_rr_pick2.sv | 33 +++
 rtl/m_dram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_m_dram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_dram_arbiter_pkg.sv
// rtl/m_dram_arbiter_pkg.sv - requester indices, FSM encodings and shared types for the DRAM arbiter
package m_dram_arbiter_pkg;

  localparam int ARB_PTW   = 0;
  localparam int ARB_DATA  = 1;
  localparam int ARB_FETCH = 2;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_DONE  = 2'd3;

  typedef logic [2:0] arb_vec_t;

  localparam logic [3:0] FULL_MASK = 4'hF;

endpackage

// File: rtl/m_rr_pick2.sv
// rtl/m_rr_pick2.sv - two-way round-robin pick with a registered pointer
// pick is combinational; the pointer only moves when adv is high.
module m_rr_pick2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] pick
);

  logic ptr_q, ptr_d;

  always_comb begin
    pick  = req;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      pick = ptr_q ? 2'b10 : 2'b01;
    end
    // after serving one side, the other side is favoured next time
    if (adv && (|pick)) begin
      ptr_d = pick[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/m_dram_arbiter.sv
// rtl/m_dram_arbiter.sv - single-port DRAM arbiter for PTW, CPU data and CPU fetch
// PTW has fixed priority; data and fetch alternate through m_rr_pick2.
module m_dram_arbiter
  import m_dram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2:0]        w_req,
  input  logic [ADDR_W-1:0] w_addr0,
  input  logic [ADDR_W-1:0] w_addr1,
  input  logic [ADDR_W-1:0] w_addr2,
  input  logic [2:0]        w_we,
  input  logic [DATA_W-1:0] w_wdata0,
  input  logic [DATA_W-1:0] w_wdata1,
  input  logic [3:0]        w_wmask1,
  output logic [2:0]        w_gnt,
  output logic [2:0]        w_done,
  output logic              w_err,
  output logic [DATA_W-1:0] w_rdata,
  output logic              w_dram_le,
  output logic [ADDR_W-1:0] w_dram_addr,
  output logic              w_dram_we,
  output logic [DATA_W-1:0] w_dram_wdata,
  output logic [3:0]        w_dram_mask,
  input  logic              w_dram_busy,
  input  logic [DATA_W-1:0] w_dram_odata
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]        state_q, state_d;
  arb_vec_t          gnt_q, gnt_d, done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              le_q, le_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [WD_W-1:0]   wdog_q, wdog_d, wdog_next;
  logic              armed_q, armed_d;

  logic       launch, rr_adv, wd_hit;
  logic [1:0] rr_pick;
  arb_vec_t   win;
  logic       unused_fetch_we;

  assign unused_fetch_we = w_we[ARB_FETCH];

  assign launch = (state_q == ARB_IDLE) && !w_dram_busy && (|w_req);
  assign rr_adv = launch && !w_req[ARB_PTW];

  m_rr_pick2 u_rr (
    .clk  (CLK),
    .rst  (RST),
    .req  (w_req[ARB_FETCH:ARB_DATA]),
    .adv  (rr_adv),
    .pick (rr_pick)
  );

  assign win       = w_req[ARB_PTW] ? 3'b001 : {rr_pick, 1'b0};
  assign wdog_next = wdog_q + WD_W'(1);
  assign wd_hit    = (TIMEOUT > 0) && (wdog_next == WD_W'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    le_d    = 1'b0;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    wdog_d  = wdog_q;
    armed_d = armed_q;
    case (state_q)
      ARB_IDLE: begin
        if (launch) begin
          state_d = ARB_ISSUE;
          gnt_d   = win;
          le_d    = 1'b1;
          if (win[ARB_PTW]) begin
            addr_d  = w_addr0;
            we_d    = w_we[ARB_PTW];
            wdata_d = w_wdata0;
            mask_d  = FULL_MASK;
          end else if (win[ARB_DATA]) begin
            addr_d  = w_addr1;
            we_d    = w_we[ARB_DATA];
            wdata_d = w_wdata1;
            mask_d  = w_wmask1;
          end else begin
            addr_d  = w_addr2;
            we_d    = 1'b0;
            wdata_d = '0;
            mask_d  = FULL_MASK;
          end
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_WAIT;
        wdog_d  = '0;
        armed_d = 1'b0;
      end
      ARB_WAIT: begin
        wdog_d  = wdog_next;
        armed_d = 1'b1;
        // armed covers both a seen busy pulse and a zero-wait controller
        if (!w_dram_busy && armed_q) begin
          state_d = ARB_DONE;
          done_d  = gnt_q;
          rdata_d = we_q ? '0 : w_dram_odata;
        end else if (wd_hit) begin
          state_d = ARB_DONE;
          done_d  = gnt_q;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        wdog_d  = '0;
        armed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      le_q    <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      mask_q  <= '0;
      wdog_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      le_q    <= le_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      wdog_q  <= wdog_d;
      armed_q <= armed_d;
    end
  end

  assign w_gnt        = gnt_q;
  assign w_done       = done_q;
  assign w_err        = err_q;
  assign w_rdata      = rdata_q;
  assign w_dram_le    = le_q;
  assign w_dram_addr  = addr_q;
  assign w_dram_we    = we_q;
  assign w_dram_wdata = wdata_q;
  assign w_dram_mask  = mask_q;

endmodule

// File: tb/tb_m_dram_arbiter.sv
// tb/tb_m_dram_arbiter.sv - scoreboard bench for m_dram_arbiter with a small DRAM controller model
module tb_m_dram_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  w_req;
  logic [31:0] w_addr0, w_addr1, w_addr2;
  logic [2:0]  w_we;
  logic [31:0] w_wdata0, w_wdata1;
  logic [3:0]  w_wmask1;
  logic [2:0]  w_gnt, w_done;
  logic        w_err;
  logic [31:0] w_rdata;
  logic        w_dram_le;
  logic [31:0] w_dram_addr;
  logic        w_dram_we;
  logic [31:0] w_dram_wdata;
  logic [3:0]  w_dram_mask;
  logic        w_dram_busy;
  logic [31:0] w_dram_odata;

  always #5 CLK = ~CLK;

  m_dram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .w_req(w_req),
    .w_addr0(w_addr0), .w_addr1(w_addr1), .w_addr2(w_addr2),
    .w_we(w_we), .w_wdata0(w_wdata0), .w_wdata1(w_wdata1), .w_wmask1(w_wmask1),
    .w_gnt(w_gnt), .w_done(w_done), .w_err(w_err), .w_rdata(w_rdata),
    .w_dram_le(w_dram_le), .w_dram_addr(w_dram_addr), .w_dram_we(w_dram_we),
    .w_dram_wdata(w_dram_wdata), .w_dram_mask(w_dram_mask),
    .w_dram_busy(w_dram_busy), .w_dram_odata(w_dram_odata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  mask;
    bit          chk_mask;
  } launch_t;

  typedef struct {
    logic [2:0]  done;
    logic        err;
    logic [31:0] rdata;
    bit          chk_rdata;
    int          delta;
  } done_t;

  launch_t lq[$];
  done_t   dq[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int le_cyc  = 0;

  int          lat = 2;
  int          left = 0;
  bit          stuck = 0;
  bit          hold_busy = 0;
  logic [31:0] rd_val = 32'h0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // DRAM controller model: busy rises after le, odata valid when busy falls
  initial begin
    w_dram_busy  = 1'b0;
    w_dram_odata = 32'h0;
    forever begin
      @(posedge CLK);
      #2;
      if (RST) begin
        left        = 0;
        w_dram_busy = hold_busy;
      end else if (w_dram_le) begin
        left         = lat;
        w_dram_busy  = (lat > 0) || stuck;
        w_dram_odata = ((lat > 0) || stuck) ? 32'hBAD0_BAD0 : rd_val;
      end else if (stuck || hold_busy) begin
        w_dram_busy = 1'b1;
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          w_dram_busy  = 1'b0;
          w_dram_odata = rd_val;
        end
      end else begin
        w_dram_busy = 1'b0;
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT launches or completes
  initial begin
    launch_t l;
    done_t   d;
    forever begin
      @(negedge CLK);
      if (w_dram_le === 1'b1) begin
        le_cyc = cyc;
        if (lq.size() == 0) begin
          chk("le_unexpected", 32'(w_dram_le), 32'h0);
        end else begin
          l = lq.pop_front();
          chk("le_addr", w_dram_addr, l.addr);
          chk("le_we", 32'(w_dram_we), 32'(l.we));
          chk("le_wdata", w_dram_wdata, l.wdata);
          if (l.chk_mask) chk("le_mask", 32'(w_dram_mask), 32'(l.mask));
        end
      end
      if (w_done !== 3'b000) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 32'(w_done), 32'h0);
        end else begin
          d = dq.pop_front();
          chk("done_owner", 32'(w_done), 32'(d.done));
          chk("done_err", 32'(w_err), 32'(d.err));
          if (d.chk_rdata) chk("done_rdata", w_rdata, d.rdata);
          if (d.delta >= 0) chk("done_latency", 32'(cyc - le_cyc), 32'(d.delta));
        end
      end
    end
  end

  task automatic wait_dones(input int n, input int bound, input string name);
    int k = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (w_done !== 3'b000) k++;
      if (k == n) return;
    end
    expire(name);
  endtask

  task automatic wait_sig(input int which, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (which == 0 && w_gnt[0] === 1'b1) return;
      if (which == 1 && w_dram_le === 1'b1) return;
      if (which == 2 && w_dram_busy === 1'b0) return;
    end
    expire(name);
  endtask

  task automatic push_launch(input logic [31:0] a, input logic we, input logic [31:0] wd,
                             input logic [3:0] m, input bit cm);
    launch_t l;
    l.addr = a; l.we = we; l.wdata = wd; l.mask = m; l.chk_mask = cm;
    lq.push_back(l);
  endtask

  task automatic push_done(input logic [2:0] dn, input logic e, input logic [31:0] rd,
                           input bit cr, input int dl);
    done_t d;
    d.done = dn; d.err = e; d.rdata = rd; d.chk_rdata = cr; d.delta = dl;
    dq.push_back(d);
  endtask

  initial begin
    w_req = 3'b000; w_we = 3'b000; w_wmask1 = 4'h0;
    w_addr0 = 32'h0; w_addr1 = 32'h0; w_addr2 = 32'h0;
    w_wdata0 = 32'h0; w_wdata1 = 32'h0;

    repeat (2) @(negedge CLK);
    chk("rst_gnt", 32'(w_gnt), 32'h0);
    chk("rst_done", 32'(w_done), 32'h0);
    chk("rst_err", 32'(w_err), 32'h0);
    chk("rst_rdata", w_rdata, 32'h0);
    chk("rst_le", 32'(w_dram_le), 32'h0);
    chk("rst_addr", w_dram_addr, 32'h0);
    chk("rst_wdata", w_dram_wdata, 32'h0);
    chk("rst_mask", 32'(w_dram_mask), 32'h0);
    RST = 1'b0;

    // all three request; PTW drops after its grant -> PTW, data, fetch, data
    rd_val = 32'h1111_2222; lat = 2;
    w_addr0 = 32'h0000_0A00; w_addr1 = 32'h0000_0B00; w_addr2 = 32'h0000_0C00; w_wmask1 = 4'h3;
    push_launch(32'h0000_0A00, 1'b0, 32'h0, 4'hF, 1'b1);
    push_launch(32'h0000_0B00, 1'b0, 32'h0, 4'h3, 1'b1);
    push_launch(32'h0000_0C00, 1'b0, 32'h0, 4'hF, 1'b0);
    push_launch(32'h0000_0B00, 1'b0, 32'h0, 4'h3, 1'b1);
    push_done(3'b001, 1'b0, 32'h1111_2222, 1'b1, -1);
    push_done(3'b010, 1'b0, 32'h1111_2222, 1'b1, -1);
    push_done(3'b100, 1'b0, 32'h1111_2222, 1'b1, -1);
    push_done(3'b010, 1'b0, 32'h1111_2222, 1'b1, -1);
    w_req = 3'b111;
    wait_sig(0, 20, "arb_ptw_gnt");
    w_req[0] = 1'b0;
    wait_dones(4, 100, "arb_dones");
    w_req = 3'b000;
    @(negedge CLK);

    // single data read, busy for 3 cycles
    rd_val = 32'hDEAD_BEEF; lat = 3;
    w_addr1 = 32'h8000_0100; w_we = 3'b000; w_wmask1 = 4'hF;
    push_launch(32'h8000_0100, 1'b0, 32'h0, 4'hF, 1'b1);
    push_done(3'b010, 1'b0, 32'hDEAD_BEEF, 1'b1, 4);
    w_req = 3'b010;
    @(negedge CLK);
    chk("read_gnt", 32'(w_gnt), 32'h2);
    wait_dones(1, 40, "read_done");
    w_req = 3'b000;
    @(negedge CLK);

    // PTW write-back of a PTE
    rd_val = 32'h5555_AAAA; lat = 2;
    w_addr0 = 32'h0010_2004; w_wdata0 = 32'h2000_00CF; w_we = 3'b001;
    push_launch(32'h0010_2004, 1'b1, 32'h2000_00CF, 4'hF, 1'b1);
    push_done(3'b001, 1'b0, 32'h0, 1'b1, 3);
    w_req = 3'b001;
    wait_dones(1, 40, "ptw_wr_done");
    w_req = 3'b000; w_we = 3'b000;
    @(negedge CLK);

    // fetch with we set is still a read; zero-wait controller
    rd_val = 32'h0000_0013; lat = 0;
    w_addr2 = 32'h0000_4000; w_we = 3'b100;
    push_launch(32'h0000_4000, 1'b0, 32'h0, 4'hF, 1'b0);
    push_done(3'b100, 1'b0, 32'h0000_0013, 1'b1, 3);
    w_req = 3'b100;
    wait_dones(1, 40, "fetch_done");
    w_req = 3'b000; w_we = 3'b000;
    @(negedge CLK);

    // data partial write, one busy cycle
    lat = 1;
    w_addr1 = 32'h0000_0300; w_wdata1 = 32'hCAFE_F00D; w_wmask1 = 4'h5; w_we = 3'b010;
    push_launch(32'h0000_0300, 1'b1, 32'hCAFE_F00D, 4'h5, 1'b1);
    push_done(3'b010, 1'b0, 32'h0, 1'b1, 3);
    w_req = 3'b010;
    wait_dones(1, 40, "data_wr_done");
    w_req = 3'b000; w_we = 3'b000;
    @(negedge CLK);

    // watchdog abort after 15 stuck WAIT cycles
    lat = 0; stuck = 1'b1;
    w_addr1 = 32'h0000_0700; w_wdata1 = 32'h0; w_wmask1 = 4'hF;
    push_launch(32'h0000_0700, 1'b0, 32'h0, 4'hF, 1'b1);
    push_done(3'b010, 1'b1, 32'h0, 1'b0, 16);
    w_req = 3'b010;
    wait_dones(1, 60, "wdog_done");
    w_req = 3'b000; stuck = 1'b0;
    @(negedge CLK);
    chk("wdog_gnt_clear", 32'(w_gnt), 32'h0);
    repeat (2) @(negedge CLK);

    // busy held in IDLE blocks the grant
    hold_busy = 1'b1; lat = 2; rd_val = 32'h0BAD_CAFE;
    @(negedge CLK);
    w_req = 3'b010; w_addr1 = 32'h0000_0900;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("busy_idle_nogrant", 32'(w_gnt), 32'h0);
    end
    push_launch(32'h0000_0900, 1'b0, 32'h0, 4'hF, 1'b1);
    push_done(3'b010, 1'b0, 32'h0BAD_CAFE, 1'b1, -1);
    hold_busy = 1'b0;
    wait_sig(2, 10, "busy_release");
    chk("busy_release_nogrant", 32'(w_gnt), 32'h0);
    @(negedge CLK);
    chk("busy_release_gnt", 32'(w_gnt), 32'h2);
    wait_dones(1, 40, "busy_idle_done");
    w_req = 3'b000;
    @(negedge CLK);

    // asynchronous reset in WAIT, then a normal grant
    stuck = 1'b1; lat = 0;
    w_addr1 = 32'h0000_0D00;
    push_launch(32'h0000_0D00, 1'b0, 32'h0, 4'hF, 1'b1);
    w_req = 3'b010;
    wait_sig(1, 20, "rst_le");
    repeat (3) @(negedge CLK);
    #2;
    RST = 1'b1; stuck = 1'b0;
    #1;
    chk("arst_gnt", 32'(w_gnt), 32'h0);
    chk("arst_le", 32'(w_dram_le), 32'h0);
    chk("arst_addr", w_dram_addr, 32'h0);
    chk("arst_mask", 32'(w_dram_mask), 32'h0);
    chk("arst_done", 32'(w_done), 32'h0);
    repeat (2) @(negedge CLK);
    lat = 2; rd_val = 32'h7777_0001;
    push_launch(32'h0000_0D00, 1'b0, 32'h0, 4'hF, 1'b1);
    push_done(3'b010, 1'b0, 32'h7777_0001, 1'b1, 3);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_gnt", 32'(w_gnt), 32'h2);
    wait_dones(1, 40, "post_rst_done");
    w_req = 3'b000;

    repeat (3) @(negedge CLK);
    chk("launch_queue_empty", 32'(lq.size()), 32'h0);
    chk("done_queue_empty", 32'(dq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
